// File: rtl/rv_instr_enc.sv
`default_nettype none
// ============================================================================
// Module   : rv_instr_enc
// Brief    : Two-stage RISC-V base instruction encoder with immediate range
//            checking, valid/ready handshakes and a saturating error counter.
// Revision : 1.0
// ============================================================================
module rv_instr_enc (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [2:0]  fmt_i,
    input  logic [6:0]  opcode_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [63:0] imm_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] instr_o,
    output logic        err_o,
    output logic [15:0] err_cnt_o
);

    localparam logic [2:0]  c_FMT_R   = 3'd0;
    localparam logic [2:0]  c_FMT_I   = 3'd1;
    localparam logic [2:0]  c_FMT_ISH = 3'd2;
    localparam logic [2:0]  c_FMT_S   = 3'd3;
    localparam logic [2:0]  c_FMT_B   = 3'd4;
    localparam logic [2:0]  c_FMT_U   = 3'd5;
    localparam logic [2:0]  c_FMT_J   = 3'd6;
    localparam logic [31:0] c_NOP     = 32'h0000_0013;
    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    logic        r_s1_valid;
    logic        r_s1_err;
    logic [2:0]  r_s1_fmt;
    logic [6:0]  r_s1_opcode;
    logic [4:0]  r_s1_rd;
    logic [4:0]  r_s1_rs1;
    logic [4:0]  r_s1_rs2;
    logic [2:0]  r_s1_funct3;
    logic [6:0]  r_s1_funct7;
    logic [31:0] r_s1_imm;

    logic        r_s2_valid;
    logic        r_s2_err;
    logic [31:0] r_s2_instr;
    logic [15:0] r_err_cnt;

    logic        w_s1_ready;
    logic        w_s2_ready;
    logic        w_range_ok;
    logic        w_sx11;
    logic        w_sx12;
    logic        w_sx20;
    logic        w_sx31;
    logic [31:0] w_word;

    assign w_s2_ready = !r_s2_valid || out_ready_i;
    assign w_s1_ready = !r_s1_valid || w_s2_ready;
    assign in_ready_o = w_s1_ready;

    // Sign-extension checks: every bit above the top encodable bit must match it.
    assign w_sx11 = (&imm_i[63:11]) || !(|imm_i[63:11]);
    assign w_sx12 = (&imm_i[63:12]) || !(|imm_i[63:12]);
    assign w_sx20 = (&imm_i[63:20]) || !(|imm_i[63:20]);
    assign w_sx31 = (&imm_i[63:31]) || !(|imm_i[63:31]);

    always_comb begin
        w_range_ok = 1'b0;
        case (fmt_i)
            c_FMT_R:   w_range_ok = 1'b1;
            c_FMT_I:   w_range_ok = w_sx11;
            c_FMT_ISH: w_range_ok = !(|imm_i[63:5]);
            c_FMT_S:   w_range_ok = w_sx11;
            c_FMT_B:   w_range_ok = !imm_i[0] && w_sx12;
            c_FMT_U:   w_range_ok = !(|imm_i[11:0]) && w_sx31;
            c_FMT_J:   w_range_ok = !imm_i[0] && w_sx20;
            default:   w_range_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s1_valid  <= 1'b0;
            r_s1_err    <= 1'b0;
            r_s1_fmt    <= 3'd0;
            r_s1_opcode <= 7'd0;
            r_s1_rd     <= 5'd0;
            r_s1_rs1    <= 5'd0;
            r_s1_rs2    <= 5'd0;
            r_s1_funct3 <= 3'd0;
            r_s1_funct7 <= 7'd0;
            r_s1_imm    <= 32'd0;
        end else if (w_s1_ready) begin
            r_s1_valid <= in_valid_i;
            if (in_valid_i) begin
                r_s1_err    <= !w_range_ok;
                r_s1_fmt    <= fmt_i;
                r_s1_opcode <= opcode_i;
                r_s1_rd     <= rd_i;
                r_s1_rs1    <= rs1_i;
                r_s1_rs2    <= rs2_i;
                r_s1_funct3 <= funct3_i;
                r_s1_funct7 <= funct7_i;
                // Range already verified, so the low 32 bits carry the full value.
                r_s1_imm    <= imm_i[31:0];
            end
        end
    end

    always_comb begin
        w_word = c_NOP;
        if (!r_s1_err) begin
            case (r_s1_fmt)
                c_FMT_R:   w_word = {r_s1_funct7, r_s1_rs2, r_s1_rs1, r_s1_funct3,
                                     r_s1_rd, r_s1_opcode};
                c_FMT_I:   w_word = {r_s1_imm[11:0], r_s1_rs1, r_s1_funct3,
                                     r_s1_rd, r_s1_opcode};
                c_FMT_ISH: w_word = {r_s1_funct7, r_s1_imm[4:0], r_s1_rs1,
                                     r_s1_funct3, r_s1_rd, r_s1_opcode};
                c_FMT_S:   w_word = {r_s1_imm[11:5], r_s1_rs2, r_s1_rs1,
                                     r_s1_funct3, r_s1_imm[4:0], r_s1_opcode};
                c_FMT_B:   w_word = {r_s1_imm[12], r_s1_imm[10:5], r_s1_rs2,
                                     r_s1_rs1, r_s1_funct3, r_s1_imm[4:1],
                                     r_s1_imm[11], r_s1_opcode};
                c_FMT_U:   w_word = {r_s1_imm[31:12], r_s1_rd, r_s1_opcode};
                c_FMT_J:   w_word = {r_s1_imm[20], r_s1_imm[10:1], r_s1_imm[11],
                                     r_s1_imm[19:12], r_s1_rd, r_s1_opcode};
                default:   w_word = c_NOP;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s2_valid <= 1'b0;
            r_s2_err   <= 1'b0;
            r_s2_instr <= 32'd0;
        end else if (w_s2_ready) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_err   <= r_s1_err;
                r_s2_instr <= w_word;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_err_cnt <= 16'd0;
        end else if (r_s2_valid && out_ready_i && r_s2_err && (r_err_cnt != c_CNT_MAX)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign out_valid_o = r_s2_valid;
    assign instr_o     = r_s2_instr;
    assign err_o       = r_s2_err;
    assign err_cnt_o   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rv_instr_enc.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv_instr_enc
// Brief    : Directed and randomized bench for rv_instr_enc; outputs are
//            decoded back into fields and compared with the accepted requests.
// Revision : 1.0
// ============================================================================
module tb_rv_instr_enc;

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [63:0] imm;
    } req_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [63:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic        err;
    logic [15:0] err_cnt;

    req_t        q[$];
    int          errors = 0;
    int          checks = 0;
    int          exp_cnt = 0;
    bit          prev_hold = 1'b0;
    logic [31:0] prev_instr;
    logic        prev_err;
    bit          acc;

    rv_instr_enc u_dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .fmt_i       (fmt),
        .opcode_i    (opcode),
        .rd_i        (rd),
        .rs1_i       (rs1),
        .rs2_i       (rs2),
        .funct3_i    (funct3),
        .funct7_i    (funct7),
        .imm_i       (imm),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .instr_o     (instr),
        .err_o       (err),
        .err_cnt_o   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Legality expressed as plain signed-integer ranges.
    function automatic bit is_legal(input req_t r);
        longint s;
        s = longint'(r.imm);
        case (r.fmt)
            3'd0:    return 1'b1;
            3'd1,
            3'd3:    return (s >= -2048) && (s <= 2047);
            3'd2:    return (s >= 0) && (s <= 31);
            3'd4:    return (r.imm[0] == 1'b0) && (s >= -4096) && (s <= 4095);
            3'd5:    return (r.imm[11:0] == 12'd0) &&
                            (s >= -(longint'(1) <<< 31)) && (s < (longint'(1) <<< 31));
            3'd6:    return (r.imm[0] == 1'b0) &&
                            (s >= -(longint'(1) <<< 20)) && (s < (longint'(1) <<< 20));
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [63:0] sext(input logic [31:0] v, input int top);
        longint x;
        x = longint'({32'd0, v});
        return 64'(x - ((x >>> top) & 64'd1) * (longint'(1) <<< (top + 1)));
    endfunction

    // Decode the delivered word and compare it with the originating request.
    task automatic check_word(input req_t r, input logic [31:0] w, input logic e);
        bit lg;
        lg = is_legal(r);
        check("err", {63'd0, e}, {63'd0, !lg});
        if (!lg) begin
            check("nop", {32'd0, w}, 64'h13);
        end else begin
            check("opcode", {57'd0, w[6:0]}, {57'd0, r.op});
            case (r.fmt)
                3'd0: check("r_fields", {39'd0, w[31:7]}, {39'd0, r.f7, r.rs2, r.rs1, r.f3, r.rd});
                3'd1: begin
                    check("i_fields", {51'd0, w[19:7]}, {51'd0, r.rs1, r.f3, r.rd});
                    check("i_imm", sext({20'd0, w[31:20]}, 11), r.imm);
                end
                3'd2: begin
                    check("ish_fields", {44'd0, w[31:25], w[19:7]}, {44'd0, r.f7, r.rs1, r.f3, r.rd});
                    check("ish_imm", {59'd0, w[24:20]}, r.imm);
                end
                3'd3: begin
                    check("s_fields", {51'd0, w[24:12]}, {51'd0, r.rs2, r.rs1, r.f3});
                    check("s_imm", sext({20'd0, w[31:25], w[11:7]}, 11), r.imm);
                end
                3'd4: begin
                    check("b_fields", {51'd0, w[24:12]}, {51'd0, r.rs2, r.rs1, r.f3});
                    check("b_imm", sext({19'd0, w[31], w[7], w[30:25], w[11:8], 1'b0}, 12), r.imm);
                end
                3'd5: begin
                    check("u_fields", {59'd0, w[11:7]}, {59'd0, r.rd});
                    check("u_imm", sext({w[31:12], 12'd0}, 31), r.imm);
                end
                3'd6: begin
                    check("j_fields", {59'd0, w[11:7]}, {59'd0, r.rd});
                    check("j_imm", sext({11'd0, w[31], w[19:12], w[20], w[30:21], 1'b0}, 20), r.imm);
                end
                default: check("fmt_path", 64'd1, 64'd0);
            endcase
        end
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic step(output bit accepted);
        req_t cur;
        #4;
        accepted = 1'b0;
        cur.fmt = fmt; cur.op = opcode; cur.rd = rd; cur.rs1 = rs1; cur.rs2 = rs2;
        cur.f3 = funct3; cur.f7 = funct7; cur.imm = imm;
        if (prev_hold)
            check("hold", {31'd0, out_valid, err, instr}, {31'd0, 1'b1, prev_err, prev_instr});
        check("err_cnt", {48'd0, err_cnt}, 64'(exp_cnt));
        if (rst) begin
            q.delete();
            exp_cnt = 0;
            prev_hold = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                q.push_back(cur);
                accepted = 1'b1;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) check("spurious", 64'd1, 64'd0);
                else check_word(q.pop_front(), instr, err);
                if (err && exp_cnt != 65535) exp_cnt++;
            end
            prev_hold = out_valid && !out_ready;
            prev_instr = instr;
            prev_err = err;
        end
        @(negedge clk);
    endtask

    task automatic set_req(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                           input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [63:0] im);
        in_valid = 1'b1; fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2;
        funct3 = f3; funct7 = f7; imm = im;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && (q.size() != 0 || out_valid); i++) step(acc);
        check("drain", 64'(q.size()), 64'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        set_req(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'd0);
        in_valid = 1'b0;
        step(acc);
        step(acc);
        rst = 1'b0;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_instr", {32'd0, instr}, 64'd0);
        check("rst_err", {63'd0, err}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Addi x1, x0, -1 with two-cycle latency.
        set_req(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        step(acc);
        check("lat_accept", {63'd0, acc}, 64'd1);
        in_valid = 1'b0;
        check("lat_1cyc", {63'd0, out_valid}, 64'd0);
        step(acc);
        check("lat_2cyc", {63'd0, out_valid}, 64'd1);
        check("addi_word", {32'd0, instr}, 64'hFFF0_0093);
        step(acc);

        set_req(3'd4, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -64'sd4);
        step(acc); in_valid = 1'b0; step(acc);
        check("beq_word", {32'd0, instr}, 64'hFE20_8EE3);
        check("beq_err", {63'd0, err}, 64'd0);
        step(acc);

        set_req(3'd5, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 64'h1234_5000);
        step(acc); in_valid = 1'b0; step(acc);
        check("lui_word", {32'd0, instr}, 64'h1234_52B7);
        step(acc);

        set_req(3'd4, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 64'd3);
        step(acc); in_valid = 1'b0; step(acc);
        check("bmis_word", {32'd0, instr}, 64'h13);
        check("bmis_err", {63'd0, err}, 64'd1);
        step(acc);
        check("bmis_cnt", {48'd0, err_cnt}, 64'd1);
        set_req(3'd5, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 64'h1234_5001);
        step(acc); in_valid = 1'b0; step(acc);
        check("umis_err", {63'd0, err}, 64'd1);
        step(acc);
        check("umis_cnt", {48'd0, err_cnt}, 64'd2);

        // Backpressure: only two of three back-to-back requests fit.
        out_ready = 1'b0;
        set_req(3'd1, 7'b0010011, 5'd3, 5'd4, 5'd0, 3'd0, 7'd0, 64'd10);
        step(acc);
        set_req(3'd1, 7'b0010011, 5'd3, 5'd4, 5'd0, 3'd0, 7'd0, 64'd11);
        step(acc);
        set_req(3'd1, 7'b0010011, 5'd3, 5'd4, 5'd0, 3'd0, 7'd0, 64'd12);
        check("bp_full", {63'd0, in_ready}, 64'd0);
        step(acc); step(acc);
        check("bp_q", 64'(q.size()), 64'd2);
        out_ready = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 10 && !acc; i++) step(acc);
        check("bp_third_acc", {63'd0, acc}, 64'd1);
        drain();

        // Reset with both stages full: nothing queued may reappear.
        out_ready = 1'b0;
        set_req(3'd2, 7'b0010011, 5'd7, 5'd8, 5'd0, 3'd1, 7'd0, 64'd99);
        step(acc); step(acc);
        in_valid = 1'b0;
        rst = 1'b1;
        step(acc);
        rst = 1'b0;
        check("rst2_valid", {63'd0, out_valid}, 64'd0);
        check("rst2_cnt", {48'd0, err_cnt}, 64'd0);
        check("rst2_ready", {63'd0, in_ready}, 64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step(acc);

        for (int i = 0; i < 600; i++) begin
            logic [63:0] im;
            case ($urandom % 5)
                0: im = {$urandom, $urandom};
                1: im = 64'(longint'($urandom_range(0, 8191)) - 4096);
                2: im = 64'(longint'(int'($urandom))) & ~64'hFFF;
                3: im = 64'(longint'($urandom_range(0, 32'h1FFFFF)) - 32'h100000);
                default: im = 64'($urandom_range(0, 40));
            endcase
            if ($urandom % 3 != 0) im[0] = 1'b0;
            set_req(3'($urandom), 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                    3'($urandom), 7'($urandom), im);
            in_valid = ($urandom % 4) != 0;
            out_ready = ($urandom % 4) != 0;
            step(acc);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
